// File: rtl/comparator_pkg.sv
// Shared constants for the registered magnitude/equality comparator.
// Results use the one-hot vector {GT, LT, E}.
package comparator_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_CNT_W = 8;

  typedef logic [2:0] res_t;

  localparam res_t RES_EQ = 3'b001;
  localparam res_t RES_LT = 3'b010;
  localparam res_t RES_GT = 3'b100;

  function automatic res_t pack_result(input logic eq, input logic lt, input logic gt);
    return {gt, lt, eq};
  endfunction

endpackage

// File: rtl/comparator_core.sv
// Combinational unsigned compare built as an MSB-first bit-slice chain.
// The first differing bit from the top decides the LT/GT direction.
module comparator_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  // Index k carries the state after examining bits WIDTH-1 down to k.
  logic [WIDTH:0] decided;
  logic [WIDTH:0] lt_chain;

  assign decided[WIDTH]  = 1'b0;
  assign lt_chain[WIDTH] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    assign decided[i]  = decided[i+1] | (a[i] ^ b[i]);
    assign lt_chain[i] = decided[i+1] ? lt_chain[i+1] : (~a[i] & b[i]);
  end

  assign eq = ~decided[0];
  assign lt = lt_chain[0];
  assign gt = decided[0] & ~lt_chain[0];

endmodule

// File: rtl/comparator.sv
// Registered comparator with a one-hot result, a saturating equal-result
// counter and a sticky mismatch flag.
module comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  input  logic             clr,
  output logic             E,
  output logic             LT,
  output logic             GT,
  output logic             out_valid,
  output logic [CNT_W-1:0] eq_count,
  output logic             mismatch_seen
);

  logic             cmp_eq, cmp_lt, cmp_gt;
  res_t             res_d, res_q;
  logic             valid_d, valid_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             seen_d, seen_q;

  comparator_core #(.WIDTH(WIDTH)) u_core (
    .a  (A),
    .b  (B),
    .eq (cmp_eq),
    .lt (cmp_lt),
    .gt (cmp_gt)
  );

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    res_d   = res_q;
    valid_d = in_valid;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    if (in_valid) begin
      res_d = pack_result(cmp_eq, cmp_lt, cmp_gt);
      if (cmp_eq && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
      if (!cmp_eq) seen_d = 1'b1;
    end
    if (clr) begin
      cnt_d  = '0;
      seen_d = 1'b0;
    end
  end

  // Reset value E=1 mirrors the idle A=B=0 state; out_valid=0 qualifies it.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state flops use non-blocking assignments to avoid ordering races.
    if (!rst_n) begin
      res_q   <= RES_EQ;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
    end else begin
      res_q   <= res_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
    end
  end

  assign E             = res_q[0];
  assign LT            = res_q[1];
  assign GT            = res_q[2];
  assign out_valid     = valid_q;
  assign eq_count      = cnt_q;
  assign mismatch_seen = seen_q;

endmodule

// File: tb/tb_comparator.sv
// Scoreboard bench for comparator: stimulus pushes expected results, a monitor
// pops and compares whenever out_valid is presented.
module tb_comparator;
  import comparator_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] A = '0, B = '0;
  logic       in_valid = 1'b0, clr = 1'b0;
  logic       E, LT, GT, out_valid, mismatch_seen;
  logic [7:0] eq_count;
  logic       s_E, s_LT, s_GT, s_out_valid, s_mismatch_seen;
  logic [3:0] s_eq_count;

  comparator #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .in_valid(in_valid), .clr(clr),
    .E(E), .LT(LT), .GT(GT), .out_valid(out_valid),
    .eq_count(eq_count), .mismatch_seen(mismatch_seen)
  );

  comparator #(.WIDTH(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .in_valid(in_valid), .clr(clr),
    .E(s_E), .LT(s_LT), .GT(s_GT), .out_valid(s_out_valid),
    .eq_count(s_eq_count), .mismatch_seen(s_mismatch_seen)
  );

  always #5 clk = ~clk;

  typedef struct {
    res_t       res;
    logic [7:0] cnt8;
    logic [3:0] cnt4;
    logic       seen;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  res_t       m_res  = RES_EQ;
  logic [7:0] m_cnt8 = '0;
  logic [3:0] m_cnt4 = '0;
  logic       m_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and update the model.
  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic v,
                       input logic c, input res_t exp_res);
    @(negedge clk);
    A = a; B = b; in_valid = v; clr = c;
    if (v) begin
      m_res = exp_res;
      if (exp_res == RES_EQ) begin
        if (m_cnt8 != 8'hff) m_cnt8 = m_cnt8 + 8'd1;
        if (m_cnt4 != 4'hf)  m_cnt4 = m_cnt4 + 4'd1;
      end else begin
        m_seen = 1'b1;
      end
    end
    if (c) begin
      m_cnt8 = '0;
      m_cnt4 = '0;
      m_seen = 1'b0;
    end
    if (v) sb.push_back('{m_res, m_cnt8, m_cnt4, m_seen});
  endtask

  function automatic res_t ref_cmp(input logic [3:0] a, input logic [3:0] b);
    if (a == b) return RES_EQ;
    if (a < b)  return RES_LT;
    return RES_GT;
  endfunction

  // Monitor: sample after the rising edge has settled.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          x = sb.pop_front();
          check("result", 32'({GT, LT, E}), 32'(x.res));
          check("onehot", 32'($countones({GT, LT, E})), 32'd1);
          check("eq_count", 32'(eq_count), 32'(x.cnt8));
          check("eq_count_sat", 32'(s_eq_count), 32'(x.cnt4));
          check("mismatch_seen", 32'(mismatch_seen), 32'(x.seen));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct { logic [3:0] a; logic [3:0] b; res_t r; } vec_t;
  vec_t dir_vecs[4] = '{
    '{4'b0101, 4'b1101, RES_LT},
    '{4'b0101, 4'b0011, RES_GT},
    '{4'b0010, 4'b0100, RES_LT},
    '{4'b1111, 4'b1010, RES_GT}
  };

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_result", 32'({GT, LT, E}), 32'(RES_EQ));
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_eq_count", 32'(eq_count), 32'd0);
    check("rst_mismatch", 32'(mismatch_seen), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Equal sweep.
    for (int i = 0; i < 16; i++) issue(4'(i), 4'(i), 1'b1, 1'b0, RES_EQ);
    issue(4'd0, 4'd0, 1'b0, 1'b0, RES_EQ);
    @(posedge clk); #3;
    check("sweep_eq_count", 32'(eq_count), 32'd16);
    check("sweep_mismatch", 32'(mismatch_seen), 32'd0);

    // Hand-computed unequal pairs, back to back.
    for (int i = 0; i < 4; i++) issue(dir_vecs[i].a, dir_vecs[i].b, 1'b1, 1'b0, dir_vecs[i].r);

    // Hold/qualify: inputs move with in_valid low.
    issue(4'd3, 4'd3, 1'b0, 1'b0, RES_EQ);
    issue(4'd0, 4'd9, 1'b0, 1'b0, RES_EQ);
    @(posedge clk); #3;
    check("hold_out_valid", 32'(out_valid), 32'd0);
    check("hold_result", 32'({GT, LT, E}), 32'(RES_GT));
    check("hold_eq_count", 32'(eq_count), 32'd16);
    check("hold_mismatch", 32'(mismatch_seen), 32'd1);

    // Saturation of the 4-bit counter, then clear alongside an equal pair.
    for (int i = 0; i < 20; i++) issue(4'(i), 4'(i), 1'b1, 1'b0, RES_EQ);
    issue(4'd7, 4'd7, 1'b1, 1'b1, RES_EQ);
    issue(4'd0, 4'd0, 1'b0, 1'b0, RES_EQ);
    @(posedge clk); #3;
    check("clr_eq_count", 32'(eq_count), 32'd0);
    check("clr_eq_count_sat", 32'(s_eq_count), 32'd0);
    check("clr_mismatch", 32'(mismatch_seen), 32'd0);

    // Exhaustive pairs against the reference compare.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        issue(4'(a), 4'(b), 1'b1, 1'b0, ref_cmp(4'(a), 4'(b)));

    // Asynchronous reset between edges drops the in-flight pair.
    issue(4'd2, 4'd9, 1'b1, 1'b0, RES_LT);
    #1 rst_n = 1'b0;
    sb.delete();
    m_res = RES_EQ; m_cnt8 = '0; m_cnt4 = '0; m_seen = 1'b0;
    in_valid = 1'b0;
    #1;
    check("async_rst_result", 32'({GT, LT, E}), 32'(RES_EQ));
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_eq_count", 32'(eq_count), 32'd0);
    check("async_rst_mismatch", 32'(mismatch_seen), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(4'd9, 4'd2, 1'b1, 1'b0, RES_GT);
    issue(4'd5, 4'd5, 1'b1, 1'b0, RES_EQ);
    issue(4'd0, 4'd0, 1'b0, 1'b0, RES_EQ);

    repeat (3) @(posedge clk);
    #4;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/comparator.md
# comparator

Registered N-bit magnitude/equality comparator (default 4-bit). Operands A and B are sampled with a valid strobe, and the block returns a one-hot result: equal, less-than or greater-than. It also keeps a saturating count of equal results and a sticky mismatch flag. It sits in datapath checking logic, where a single-cycle registered compare result with qualification is needed.

## Interface
- WIDTH, 4: operand width in bits; legal range 1–32.
- CNT_W, 8: width of the equal-result counter.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- A  in  WIDTH  operand A, unsigned.
- B  in  WIDTH  operand B, unsigned.
- in_valid  in  1  A/B are sampled when high at a clk rising edge.
- clr  in  1  synchronous clear of eq_count and mismatch_seen.
- E  out  1  registered: A == B for the last sampled pair.
- LT  out  1  registered: A < B (unsigned).
- GT  out  1  registered: A > B (unsigned).
- out_valid  out  1  E/LT/GT correspond to a pair sampled on the previous edge.
- eq_count  out  CNT_W  number of sampled pairs with E=1; saturates at all-ones.
- mismatch_seen  out  1  sticky; set on the first sampled pair with A != B.

## Operation
- Compare is unsigned, bitwise from MSB down. E=1 iff all bits match.
- If E=0, the first differing bit decides LT/GT: A bit 0 gives LT=1; A bit 1 gives GT=1.
- Exactly one of E/LT/GT is high whenever out_valid=1.
- in_valid=1 at an edge: E/LT/GT load the new result; out_valid=1.
- in_valid=0 at an edge: E/LT/GT hold their previous values; out_valid=0.
- Counter and flag update on every sampled pair:
  - eq_count increments by 1 when the new E=1, and stops at 2^CNT_W-1 (no wrap).
  - mismatch_seen sets when the new E=0.
- clr=1 at an edge: eq_count←0 and mismatch_seen←0, taking priority over that cycle's update. E/LT/GT/out_valid still update from in_valid.
- No backpressure: the block accepts one pair per cycle, back-to-back.

## Timing
- Latency is 1 cycle: a pair sampled at edge n is visible on E/LT/GT/out_valid after edge n.
- eq_count/mismatch_seen reflect that pair after the same edge n.
- Reset (rst_n=0, asynchronous, at any time):
  - E=1, LT=0, GT=0, out_valid=0, eq_count=0, mismatch_seen=0.
  - E=1 at reset reflects the reset-equal state A=B=0; it is qualified by out_valid=0.
- Reset asserted mid-stream drops the in-flight result. The first sample after deassertion happens at the first rising edge with rst_n=1.
- All outputs are driven directly from flops; there is no combinational path from inputs to outputs.

## Structure
- Package comparator_pkg holds:
  - the default WIDTH/CNT_W localparams;
  - the result encoding constants RES_EQ=3'b001, RES_LT=3'b010, RES_GT=3'b100, used for the one-hot {GT,LT,E} vector.
- Sub-module comparator_core: purely combinational. Inputs A, B; outputs eq, lt, gt. Implemented as a parameterized MSB-first bit-slice chain.
- Top level holds the result registers, valid flop, saturating counter and sticky flag.

## Test plan
- Equal sweep: A=B=i for i=0..15 with in_valid=1, one per cycle.
  - Each following cycle: E=1, LT=0, GT=0, out_valid=1.
  - eq_count ends at 16; mismatch_seen stays 0.
- Unequal pairs, back to back:
  - A=0101, B=1101 → E=0, LT=1.
  - A=0101, B=0011 → E=0, GT=1.
  - A=0010, B=0100 → LT=1.
  - A=1111, B=1010 → GT=1.
  - After the first pair, mismatch_seen=1 and stays 1.
- Hold/qualify: drive in_valid=0 while A/B change → E/LT/GT unchanged, out_valid=0, eq_count unchanged.
- Saturation: CNT_W=4, 20 equal pairs → eq_count=15 and stays at 15. Then clr=1 together with an equal pair → eq_count=0 after that edge.
- Async reset mid-stream: assert rst_n=0 between edges → outputs immediately go to E=1, LT=0, GT=0, out_valid=0, counters 0. The first pair after release gives the correct result one cycle later.
- Exhaustive random: all 256 A/B pairs at WIDTH=4, checked against a reference compare. Exactly one of E/LT/GT is high per valid output.
